// File: rtl/bus_demux.sv
// rtl/bus_demux.sv - one-master to two-slave request/response demultiplexer
// Address bit SEL_BIT routes each request; a cycle timer turns a stalled slave into an error response.
module bus_demux #(
   parameter int SEL_BIT = 31,
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        m_valid,
   output logic        m_ready,
   input  logic        m_we,
   input  logic [31:0] m_addr,
   input  logic [31:0] m_wdata,
   output logic        m_rvalid,
   output logic [31:0] m_rdata,
   output logic        m_err,
   output logic        s0_valid,
   input  logic        s0_ready,
   output logic        s0_we,
   output logic [31:0] s0_addr,
   output logic [31:0] s0_wdata,
   input  logic        s0_rvalid,
   input  logic [31:0] s0_rdata,
   output logic        s1_valid,
   input  logic        s1_ready,
   output logic        s1_we,
   output logic [31:0] s1_addr,
   output logic [31:0] s1_wdata,
   input  logic        s1_rvalid,
   input  logic [31:0] s1_rdata
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   state_t      state;
   logic [7:0]  timer;
   logic        sel;
   logic        we_r;
   logic [31:0] addr_r;
   logic [31:0] wdata_r;

   logic        sel_ready;
   logic        sel_rvalid;
   logic [31:0] sel_rdata;
   logic        timeout;

   always_comb begin
      sel_ready  = sel ? s1_ready  : s0_ready;
      sel_rvalid = sel ? s1_rvalid : s0_rvalid;
      sel_rdata  = sel ? s1_rdata  : s0_rdata;
      timeout    = (timer == TMO_LAST);
   end

   assign m_ready = (state == IDLE);

   // Both slaves see the captured command; only the selected one gets valid.
   assign s0_we    = we_r;
   assign s0_addr  = addr_r;
   assign s0_wdata = wdata_r;
   assign s1_we    = we_r;
   assign s1_addr  = addr_r;
   assign s1_wdata = wdata_r;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         timer    <= 8'd0;
         sel      <= 1'b0;
         we_r     <= 1'b0;
         addr_r   <= 32'd0;
         wdata_r  <= 32'd0;
         m_rvalid <= 1'b0;
         m_rdata  <= 32'd0;
         m_err    <= 1'b0;
         s0_valid <= 1'b0;
         s1_valid <= 1'b0;
      end else begin
         m_rvalid <= 1'b0;
         if (state != IDLE && timer != 8'hff)
            timer <= timer + 8'd1;
         case (state)
            IDLE: begin
               if (m_valid) begin
                  we_r     <= m_we;
                  addr_r   <= m_addr;
                  wdata_r  <= m_wdata;
                  sel      <= m_addr[SEL_BIT];
                  timer    <= 8'd0;
                  s0_valid <= ~m_addr[SEL_BIT];
                  s1_valid <= m_addr[SEL_BIT];
                  state    <= REQ;
               end
            end
            REQ: begin
               // A handshake at the timeout edge still wins; the response is awaited.
               if (sel_ready) begin
                  s0_valid <= 1'b0;
                  s1_valid <= 1'b0;
                  state    <= RESP;
               end else if (timeout) begin
                  s0_valid <= 1'b0;
                  s1_valid <= 1'b0;
                  m_rvalid <= 1'b1;
                  m_err    <= 1'b1;
                  m_rdata  <= 32'd0;
                  state    <= IDLE;
               end
            end
            RESP: begin
               if (sel_rvalid) begin
                  m_rvalid <= 1'b1;
                  m_err    <= 1'b0;
                  m_rdata  <= we_r ? 32'd0 : sel_rdata;
                  state    <= IDLE;
               end else if (timeout) begin
                  m_rvalid <= 1'b1;
                  m_err    <= 1'b1;
                  m_rdata  <= 32'd0;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bus_demux.sv
// tb/tb_bus_demux.sv - directed scoreboard bench for bus_demux
module tb_bus_demux;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        m_valid = 1'b0, m_we = 1'b0;
   logic [31:0] m_addr = 32'd0, m_wdata = 32'd0;
   logic        m_ready, m_rvalid, m_err;
   logic [31:0] m_rdata;
   logic        s0_valid, s0_we, s1_valid, s1_we;
   logic [31:0] s0_addr, s0_wdata, s1_addr, s1_wdata;
   logic        s0_ready, s0_rvalid, s1_ready, s1_rvalid;
   logic [31:0] s0_rdata, s1_rdata;

   logic        auto_mode = 1'b0;
   logic        s0_ready_d = 1'b0, s0_rvalid_d = 1'b0, s1_ready_d = 1'b0, s1_rvalid_d = 1'b0;
   logic [31:0] s0_rdata_d = 32'd0, s1_rdata_d = 32'd0;

   // In auto mode each slave is always ready and answers with a function of its address.
   assign s0_ready  = auto_mode ? 1'b1 : s0_ready_d;
   assign s0_rvalid = auto_mode ? 1'b1 : s0_rvalid_d;
   assign s0_rdata  = auto_mode ? (s0_addr ^ 32'h0F0F_0F0F) : s0_rdata_d;
   assign s1_ready  = auto_mode ? 1'b1 : s1_ready_d;
   assign s1_rvalid = auto_mode ? 1'b1 : s1_rvalid_d;
   assign s1_rdata  = auto_mode ? (s1_addr ^ 32'h0F0F_0F0F) : s1_rdata_d;

   bus_demux #(.SEL_BIT(31), .TIMEOUT(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .m_valid(m_valid), .m_ready(m_ready), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_err(m_err),
      .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_we(s0_we), .s0_addr(s0_addr),
      .s0_wdata(s0_wdata), .s0_rvalid(s0_rvalid), .s0_rdata(s0_rdata),
      .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_we(s1_we), .s1_addr(s1_addr),
      .s1_wdata(s1_wdata), .s1_rvalid(s1_rvalid), .s1_rdata(s1_rdata)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int resp_cnt = 0;
   logic [32:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Response monitor: every m_rvalid pulse must match the oldest expectation.
   always @(posedge clk) begin
      #1;
      if (rst_n && m_rvalid) begin
         resp_cnt++;
         if (exp_q.size() == 0) begin
            check("unexpected_rvalid", 32'd1, 32'd0);
         end else begin
            logic [32:0] e;
            e = exp_q.pop_front();
            check("resp_rdata", m_rdata, e[31:0]);
            check("resp_err", {31'd0, m_err}, {31'd0, e[32]});
         end
      end
   end

   initial begin
      int n;
      int base;
      logic [31:0] addrs [4];

      // reset state
      #1;
      check("rst_m_ready", {31'd0, m_ready}, 32'd1);
      check("rst_m_rvalid", {31'd0, m_rvalid}, 32'd0);
      check("rst_s0_valid", {31'd0, s0_valid}, 32'd0);
      check("rst_s1_valid", {31'd0, s1_valid}, 32'd0);
      check("rst_s0_addr", s0_addr, 32'd0);
      check("rst_m_rdata", m_rdata, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // read slave 0, minimum latency
      m_valid = 1'b1; m_we = 1'b0; m_addr = 32'h0000_0040;
      exp_q.push_back({1'b0, 32'hDEAD_BEEF});
      tick();
      m_valid = 1'b0;
      check("rd_m_ready_busy", {31'd0, m_ready}, 32'd0);
      check("rd_s0_valid", {31'd0, s0_valid}, 32'd1);
      check("rd_s1_valid", {31'd0, s1_valid}, 32'd0);
      check("rd_s0_addr", s0_addr, 32'h0000_0040);
      check("rd_s0_we", {31'd0, s0_we}, 32'd0);
      s0_ready_d = 1'b1;
      tick();
      s0_ready_d = 1'b0;
      check("rd_s0_valid_drop", {31'd0, s0_valid}, 32'd0);
      check("rd_no_early_rvalid", {31'd0, m_rvalid}, 32'd0);
      s0_rvalid_d = 1'b1; s0_rdata_d = 32'hDEAD_BEEF;
      tick();
      s0_rvalid_d = 1'b0;
      check("rd_rvalid_cycle3", {31'd0, m_rvalid}, 32'd1);
      check("rd_s1_valid_never", {31'd0, s1_valid}, 32'd0);
      tick();
      check("rd_rvalid_pulse", {31'd0, m_rvalid}, 32'd0);
      check("rd_rdata_hold", m_rdata, 32'hDEAD_BEEF);

      // write slave 1
      m_valid = 1'b1; m_we = 1'b1; m_addr = 32'h8000_0004; m_wdata = 32'h1234_5678;
      exp_q.push_back({1'b0, 32'h0});
      tick();
      m_valid = 1'b0; m_we = 1'b0;
      check("wr_s1_valid", {31'd0, s1_valid}, 32'd1);
      check("wr_s0_valid", {31'd0, s0_valid}, 32'd0);
      check("wr_s1_we", {31'd0, s1_we}, 32'd1);
      check("wr_s1_addr", s1_addr, 32'h8000_0004);
      check("wr_s1_wdata", s1_wdata, 32'h1234_5678);
      s1_ready_d = 1'b1;
      tick();
      s1_ready_d = 1'b0;
      s1_rvalid_d = 1'b1; s1_rdata_d = 32'hFFFF_0000;
      tick();
      s1_rvalid_d = 1'b0;
      check("wr_rvalid", {31'd0, m_rvalid}, 32'd1);
      tick();

      // timeout with a stalled slave 0
      m_valid = 1'b1; m_addr = 32'h0000_0100;
      exp_q.push_back({1'b1, 32'h0});
      tick();
      m_valid = 1'b0;
      n = 0;
      while (s0_valid && n < 40) begin
         n++;
         tick();
      end
      check("tmo_valid_cycles", n, 32'd16);
      check("tmo_rvalid", {31'd0, m_rvalid}, 32'd1);
      check("tmo_err", {31'd0, m_err}, 32'd1);
      s0_rvalid_d = 1'b1; s0_rdata_d = 32'h7777_7777;
      tick();
      s0_rvalid_d = 1'b0;
      check("tmo_late_rvalid", {31'd0, m_rvalid}, 32'd0);
      check("tmo_m_ready", {31'd0, m_ready}, 32'd1);
      tick();

      // rvalid on the timeout edge in RESP: timer 0..3 in REQ, ready at 4, RESP 5..15
      m_valid = 1'b1; m_addr = 32'h0000_0200;
      exp_q.push_back({1'b0, 32'hA5A5_A5A5});
      tick();
      m_valid = 1'b0;
      repeat (4) tick();
      s0_ready_d = 1'b1;
      tick();
      s0_ready_d = 1'b0;
      repeat (10) tick();
      check("race_no_early_resp", {31'd0, m_rvalid}, 32'd0);
      s0_rvalid_d = 1'b1; s0_rdata_d = 32'hA5A5_A5A5;
      tick();
      s0_rvalid_d = 1'b0;
      check("race_rvalid", {31'd0, m_rvalid}, 32'd1);
      check("race_err", {31'd0, m_err}, 32'd0);
      tick();

      // reset while waiting in RESP
      m_valid = 1'b1; m_addr = 32'h0000_0300;
      tick();
      m_valid = 1'b0;
      s0_ready_d = 1'b1;
      tick();
      s0_ready_d = 1'b0;
      rst_n = 1'b0;
      #1;
      check("arst_m_ready", {31'd0, m_ready}, 32'd1);
      check("arst_s0_valid", {31'd0, s0_valid}, 32'd0);
      check("arst_s0_addr", s0_addr, 32'd0);
      check("arst_m_rdata", m_rdata, 32'd0);
      tick();
      rst_n = 1'b1;
      s0_rvalid_d = 1'b1; s0_rdata_d = 32'h5555_AAAA;
      tick();
      s0_rvalid_d = 1'b0;
      check("arst_no_rvalid", {31'd0, m_rvalid}, 32'd0);
      check("arst_m_ready_after", {31'd0, m_ready}, 32'd1);
      tick();

      // back-to-back alternating requests with m_valid held high
      addrs[0] = 32'h0000_1000; addrs[1] = 32'h8000_2000;
      addrs[2] = 32'h0000_3000; addrs[3] = 32'h8000_4000;
      base = resp_cnt;
      auto_mode = 1'b1;
      m_valid = 1'b1; m_we = 1'b0;
      for (int i = 0; i < 4; i++) begin
         m_addr = addrs[i];
         exp_q.push_back({1'b0, addrs[i] ^ 32'h0F0F_0F0F});
         tick();
         n = 0;
         while (!m_ready && n < 20) begin
            n++;
            tick();
         end
         check("b2b_wait", n, 32'd2);
         check("b2b_rvalid_with_ready", {31'd0, m_rvalid}, 32'd1);
      end
      m_valid = 1'b0;
      tick();
      auto_mode = 1'b0;
      check("b2b_resp_count", resp_cnt - base, 32'd4);
      check("queue_drained", exp_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
